// File: rtl/stream_framer_pkg.sv
// -----------------------------------------------------------------------------
// stream_framer_pkg
// Shared types and helpers for the stream_framer block.
//   state_t   : framer FSM states (IDLE, ACTIVE, PAD)
//   cnt_width : width of the beat counter / frame_len port for a given
//               largest frame length (enough bits to hold max_frame itself)
// -----------------------------------------------------------------------------
package stream_framer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAD    = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_frame);
    return $clog2(max_frame + 1);
  endfunction

endpackage

// File: rtl/stream_framer_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry registered AXI-Stream stage. The output register carries the
// current beat; the skid register catches the one beat that may arrive in
// the same cycle the sink stalls. Both s_ready and the output side come
// straight from flops, so there is no combinational path from m_ready back
// to s_ready, and a continuously ready sink sees one beat per cycle.
//
// Ports
//   clk, reset_n      : clock, synchronous active-low reset
//   s_data / s_valid  : upstream beat
//   s_ready           : upstream ready (registered, low during reset)
//   m_data / m_valid  : downstream beat (registered)
//   m_ready           : downstream ready
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             s_fire;
  logic             out_free;
  logic             m_valid_next;
  logic             skid_valid_next;

  assign s_fire   = s_valid & s_ready;
  assign out_free = ~m_valid | m_ready;

  // s_ready tracks ~skid_valid, so an incoming beat never meets a full skid
  // register; when the output frees up it refills from skid first, else
  // directly from the upstream beat.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    m_valid_next    = m_valid;
    skid_valid_next = skid_valid;
    if (out_free) begin
      m_valid_next    = skid_valid | s_fire;
      skid_valid_next = 1'b0;
    end else if (s_fire) begin
      skid_valid_next = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the data registers are reset too, because the downstream data
      // bus must read zero during reset; they are two words, not a memory.
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      s_ready    <= 1'b0;
    end else begin
      m_valid    <= m_valid_next;
      skid_valid <= skid_valid_next;
      s_ready    <= ~skid_valid_next;
      if (out_free) begin
        if (skid_valid) begin
          m_data <= skid_data;
        end else if (s_fire) begin
          m_data <= s_data;
        end
      end else if (s_fire) begin
        skid_data <= s_data;
      end
    end
  end

endmodule

// File: rtl/stream_framer.sv
// -----------------------------------------------------------------------------
// stream_framer
// Cuts a continuous AXI-Stream into frames of a runtime-selected length,
// marking the first beat with tuser (SOF) and the last with tlast, and counts
// completed frames. The output passes through a registered two-entry skid
// buffer.
//
// Optional feature (macro STREAM_FRAMER_PAD_EN): a one-cycle flush pulse
// while a frame is open stops taking upstream beats and completes the frame
// with all-zero beats. Without the macro, flush is ignored.
//
// Ports
//   clk, reset_n                 : clock, synchronous active-low reset
//   frame_len                    : frame length in beats (0 = DEFAULT_LEN,
//                                  above MAX_FRAME = MAX_FRAME), sampled on
//                                  the first beat of each frame
//   s_axis_tdata/tvalid/tready   : upstream stream
//   m_axis_tdata/tvalid/tready   : downstream stream
//   m_axis_tlast / m_axis_tuser  : last / first beat of frame
//   frame_count                  : frames whose tlast beat left, wrapping
//   flush                        : close the current frame early (PAD_EN)
// -----------------------------------------------------------------------------
module stream_framer
  import stream_framer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_FRAME   = 65536,
  parameter int DEFAULT_LEN = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [cnt_width(MAX_FRAME)-1:0]   frame_len,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic [31:0]                       frame_count,
  input  logic                              flush
);

  localparam int                CNT_W   = cnt_width(MAX_FRAME);
  localparam int                SKID_W  = DATA_WIDTH + 2;
  localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(MAX_FRAME);
  localparam logic [CNT_W-1:0]  DEF_LEN = CNT_W'(DEFAULT_LEN);

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        len_eff;
  logic [CNT_W-1:0]        cur_len;
  logic                    is_first;
  logic                    is_last;
  logic                    in_pad;
  logic                    push;
  logic                    skid_in_valid;
  logic                    skid_in_ready;
  logic [DATA_WIDTH-1:0]   skid_in_data;
  logic [SKID_W-1:0]       skid_in;
  logic [SKID_W-1:0]       skid_out;

`ifdef STREAM_FRAMER_PAD_EN
  assign in_pad = (state == PAD);
`else
  assign in_pad = 1'b0;
  logic unused_flush;
  assign unused_flush = flush;
`endif

  // Length that a frame starting now would use, and the length governing the
  // beat being offered this cycle (live in IDLE, latched once a frame opens
  // so later frame_len changes cannot disturb it).
  always_comb begin
    if (frame_len == '0) begin
      len_eff = DEF_LEN;
    end else if (frame_len > MAX_LEN) begin
      len_eff = MAX_LEN;
    end else begin
      len_eff = frame_len;
    end
    cur_len = (state == IDLE) ? len_eff : len_q;
  end

  assign is_first = (beat_cnt == '0);
  assign is_last  = (beat_cnt == cur_len - CNT_W'(1));

  // While padding, the framer itself is the source: zero data, one beat per
  // free buffer slot, upstream held off.
  assign skid_in_valid = in_pad | s_axis_tvalid;
  assign skid_in_data  = in_pad ? '0 : s_axis_tdata;
  assign push          = skid_in_valid & skid_in_ready;
  assign s_axis_tready = skid_in_ready & ~in_pad;
  assign skid_in       = {is_first, is_last, skid_in_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      if (push) begin
        if (is_last) begin
          beat_cnt <= '0;
          state    <= IDLE;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (state == IDLE) begin
            state <= ACTIVE;
            len_q <= len_eff;
`ifdef STREAM_FRAMER_PAD_EN
          end else if (state == ACTIVE && flush) begin
            // The coincident beat has already been counted above.
            state <= PAD;
`endif
          end
        end
`ifdef STREAM_FRAMER_PAD_EN
      end else if (state == ACTIVE && flush) begin
        state <= PAD;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_count <= frame_count + 32'd1;
    end
  end

  axis_skid_buffer #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .s_data  (skid_in),
    .s_valid (skid_in_valid),
    .s_ready (skid_in_ready),
    .m_data  (skid_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = skid_out;

endmodule

// File: tb/tb_stream_framer.sv
// -----------------------------------------------------------------------------
// tb_stream_framer
// Self-checking bench for stream_framer. Inputs are driven and outputs sampled
// one tick after the falling edge; accepted beats on both sides are logged in
// queues and compared against a frame model built from the accepted input
// beats and the frame-length rules.
// -----------------------------------------------------------------------------
module tb_stream_framer;

  localparam int DW   = 32;
  localparam int MAXF = 100;
  localparam int DEFL = 64;
  localparam int CW   = $clog2(MAXF + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] frame_len = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic [31:0]   frame_count;
  logic          flush = 1'b0;

  always #5 clk = ~clk;

  stream_framer #(
    .DATA_WIDTH  (DW),
    .MAX_FRAME   (MAXF),
    .DEFAULT_LEN (DEFL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_len     (frame_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_count   (frame_count),
    .flush         (flush)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            flen;
  } in_beat_t;

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } out_beat_t;

  in_beat_t  in_q[$];
  out_beat_t obs_q[$];
  out_beat_t exp_q[$];
  int        tests_run = 0;
  int        tests_failed = 0;
  int        stall_viol = 0;
  logic      prev_stalled = 1'b0;
  out_beat_t prev_out;

  // Frame length a frame uses when its first beat carries this frame_len.
  function automatic int eff_len(input int len);
    if (len == 0) return DEFL;
    if (len > MAXF) return MAXF;
    return len;
  endfunction

  // Expected output: input data in order, cut into consecutive frames whose
  // length is fixed by the frame_len seen on each frame's first beat.
  function automatic void build_expected();
    int pos = 0;
    int flen = 1;
    exp_q.delete();
    foreach (in_q[i]) begin
      out_beat_t b;
      if (pos == 0) flen = in_q[i].flen;
      b.data = in_q[i].data;
      b.user = (pos == 0);
      b.last = (pos == flen - 1);
      exp_q.push_back(b);
      pos = b.last ? 0 : pos + 1;
    end
  endfunction

  // One clock cycle: drive, settle, log handshakes and stall stability.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input int len, input logic fl);
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = r;
    frame_len     = CW'(len);
    flush         = fl;
    #1;
    if (prev_stalled &&
        (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_out))
      stall_viol++;
    if (s_axis_tvalid && s_axis_tready)
      in_q.push_back('{data: d, flen: eff_len(len)});
    if (m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    prev_stalled = m_axis_tvalid && !m_axis_tready;
    prev_out     = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
  endtask

  task automatic send(input int n, input int len, input int vpct, input int rpct);
    int target = in_q.size() + n;
    int cyc = 0;
    while (in_q.size() < target && cyc < 5000) begin
      step($urandom_range(99) < vpct, $urandom(), $urandom_range(99) < rpct, len, 1'b0);
      cyc++;
    end
  endtask

  // Let the sink take everything, then one more cycle so frame_count settles.
  task automatic drain(input int target);
    int cyc = 0;
    while (obs_q.size() < target && cyc < 500) begin
      step(1'b0, '0, 1'b1, int'(frame_len), 1'b0);
      cyc++;
    end
    step(1'b0, '0, 1'b1, int'(frame_len), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    in_q.delete();
    obs_q.delete();
    exp_q.delete();
    prev_stalled = 1'b0;
    stall_viol = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: valid/last/user/ready=%b, expected 0000",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready});
    end
    tests_run++;
    if (m_axis_tdata !== '0 || frame_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data: tdata=%h frame_count=%0d, expected 0 and 0",
               m_axis_tdata, frame_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b valid=%b, expected 1 0",
               s_axis_tready, m_axis_tvalid);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    for (int i = 1; i <= 12; i++) step(1'b1, DW'(i), 1'b1, 4, 1'b0);
    tests_run++;
    if (in_q.size() != 12) begin
      tests_failed++;
      $display("FAIL cont_accept: got %0d input beats in 12 cycles, expected 12", in_q.size());
    end
    step(1'b0, '0, 1'b1, 4, 1'b0);
    tests_run++;
    if (obs_q.size() != 12) begin
      tests_failed++;
      $display("FAIL cont_no_bubble: got %0d output beats in 13 cycles, expected 12", obs_q.size());
    end
    drain(12);
    build_expected();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL cont_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", i,
                 obs_q[i].user, obs_q[i].last, obs_q[i].data,
                 exp_q[i].user, exp_q[i].last, exp_q[i].data);
      end
    end
    tests_run++;
    if (frame_count !== 32'd3) begin
      tests_failed++;
      $display("FAIL cont_frames: got %0d, expected 3", frame_count);
    end
  endtask

  // Shared body for tests that only differ in stimulus: compare the logged
  // output stream against the model, the stall rule and the frame count.
  task automatic test_stream(input string name, input int n, input int len,
                             input int vpct, input int rpct, input int frames);
    do_reset();
    send(n, len, vpct, rpct);
    drain(n);
    build_expected();
    tests_run++;
    if (obs_q.size() != n || in_q.size() != n) begin
      tests_failed++;
      $display("FAIL %s_count: got in=%0d out=%0d, expected %0d each",
               name, in_q.size(), obs_q.size(), n);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", name, i,
                 obs_q[i].user, obs_q[i].last, obs_q[i].data,
                 exp_q[i].user, exp_q[i].last, exp_q[i].data);
      end
    end
    tests_run++;
    if (stall_viol != 0) begin
      tests_failed++;
      $display("FAIL %s_stall: got %0d changes while stalled, expected 0", name, stall_viol);
    end
    tests_run++;
    if (frame_count !== 32'(frames)) begin
      tests_failed++;
      $display("FAIL %s_frames: got %0d, expected %0d", name, frame_count, frames);
    end
  endtask

  task automatic test_default_len();
    test_stream("deflen", 130, 0, 70, 100, 2);
  endtask

  task automatic test_len_one();
    test_stream("len1", 10, 1, 80, 50, 10);
  endtask

  task automatic test_backpressure();
    test_stream("bp", 48, 8, 80, 50, 6);
  endtask

  task automatic test_len_change();
    do_reset();
    step(1'b1, $urandom(), 1'b1, 4, 1'b0);
    send(9, 6, 100, 100);
    drain(10);
    build_expected();
    tests_run++;
    if (obs_q.size() != 10 || exp_q.size() != 10) begin
      tests_failed++;
      $display("FAIL lenchg_count: got %0d beats, expected 10", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[3].last !== 1'b1 || obs_q[4].user !== 1'b1 || obs_q[9].last !== 1'b1) begin
        tests_failed++;
        $display("FAIL lenchg_bounds: got last3=%b user4=%b last9=%b, expected 1 1 1",
                 obs_q[3].last, obs_q[4].user, obs_q[9].last);
      end
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL lenchg_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", i,
                   obs_q[i].user, obs_q[i].last, obs_q[i].data,
                   exp_q[i].user, exp_q[i].last, exp_q[i].data);
        end
      end
    end
    tests_run++;
    if (frame_count !== 32'd2) begin
      tests_failed++;
      $display("FAIL lenchg_frames: got %0d, expected 2", frame_count);
    end
  endtask

  // Oversized frame_len clamps to MAX_FRAME; then exactly MAX_FRAME.
  task automatic test_clamp();
    do_reset();
    send(100, 127, 90, 90);
    send(100, MAXF, 90, 90);
    drain(200);
    build_expected();
    tests_run++;
    if (obs_q.size() != 200) begin
      tests_failed++;
      $display("FAIL clamp_count: got %0d beats, expected 200", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL clamp_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", i,
                 obs_q[i].user, obs_q[i].last, obs_q[i].data,
                 exp_q[i].user, exp_q[i].last, exp_q[i].data);
      end
    end
    tests_run++;
    if (frame_count !== 32'd2) begin
      tests_failed++;
      $display("FAIL clamp_frames: got %0d, expected 2", frame_count);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    // Two beats of an 8-beat frame are left sitting in the stalled output stage.
    step(1'b1, $urandom(), 1'b0, 8, 1'b0);
    step(1'b1, $urandom(), 1'b0, 8, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready} !== 4'b0000 ||
        m_axis_tdata !== '0 || frame_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrst_state: valid/last/user/ready=%b tdata=%h count=%0d, expected 0000 0 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready}, m_axis_tdata, frame_count);
    end
    reset_n = 1'b1;
    in_q.delete();
    obs_q.delete();
    prev_stalled = 1'b0;
    stall_viol = 0;
    send(8, 8, 100, 100);
    tests_run++;
    if (obs_q.size() == 0 || obs_q[0].user !== 1'b1 || obs_q[0].data !== in_q[0].data ||
        frame_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrst_first: got %0d beats, count=%0d, expected first beat with SOF and count 0",
               obs_q.size(), frame_count);
    end
    drain(8);
    build_expected();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL midrst_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", i,
                 obs_q[i].user, obs_q[i].last, obs_q[i].data,
                 exp_q[i].user, exp_q[i].last, exp_q[i].data);
      end
    end
    tests_run++;
    if (obs_q.size() != 8 || frame_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL midrst_frames: got %0d beats count=%0d, expected 8 beats count 1",
               obs_q.size(), frame_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    send(2, 5, 100, 100);
    step(1'b0, '0, 1'b1, 5, 1'b1);
`ifdef STREAM_FRAMER_PAD_EN
    for (int i = 0; i < 3; i++) step(1'b1, $urandom(), 1'b1, 5, 1'b0);
    tests_run++;
    if (in_q.size() != 2) begin
      tests_failed++;
      $display("FAIL flush_ready: got %0d input beats taken during padding, expected 0",
               in_q.size() - 2);
    end
    drain(5);
    exp_q.delete();
    exp_q.push_back('{1'b1, 1'b0, in_q[0].data});
    exp_q.push_back('{1'b0, 1'b0, in_q[1].data});
    exp_q.push_back('{1'b0, 1'b0, 32'd0});
    exp_q.push_back('{1'b0, 1'b0, 32'd0});
    exp_q.push_back('{1'b0, 1'b1, 32'd0});
`else
    send(3, 5, 100, 100);
    drain(5);
    build_expected();
`endif
    tests_run++;
    if (obs_q.size() != 5) begin
      tests_failed++;
      $display("FAIL flush_count: got %0d beats, expected 5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL flush_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", i,
                 obs_q[i].user, obs_q[i].last, obs_q[i].data,
                 exp_q[i].user, exp_q[i].last, exp_q[i].data);
      end
    end
    tests_run++;
    if (frame_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL flush_frames: got %0d, expected 1", frame_count);
    end
  endtask

  // Flush on the very beat that closes the frame: nothing is padded.
  task automatic test_flush_last();
    do_reset();
    send(2, 3, 100, 100);
    step(1'b1, $urandom(), 1'b1, 3, 1'b1);
    send(3, 3, 100, 100);
    drain(6);
    build_expected();
    tests_run++;
    if (obs_q.size() != 6 || in_q.size() != 6) begin
      tests_failed++;
      $display("FAIL flushlast_count: got in=%0d out=%0d, expected 6 each",
               in_q.size(), obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL flushlast_beat[%0d]: got u=%b l=%b d=%h, expected u=%b l=%b d=%h", i,
                 obs_q[i].user, obs_q[i].last, obs_q[i].data,
                 exp_q[i].user, exp_q[i].last, exp_q[i].data);
      end
    end
    tests_run++;
    if (frame_count !== 32'd2) begin
      tests_failed++;
      $display("FAIL flushlast_frames: got %0d, expected 2", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_default_len();
    test_len_one();
    test_backpressure();
    test_len_change();
    test_clamp();
    test_reset_midframe();
    test_flush();
    test_flush_last();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
